display_buffer_sink: RTL

DISPLAY_BUFFER_SINK -- requirements
Module: display_buffer_sink

---
 rtl/display_buffer_sink_pkg.sv | 26 ++
 rtl/display_buffer_ram.sv | 31 +++
 rtl/display_buffer_sink.sv | 97 +++++++++
 3 files changed

// File: rtl/display_buffer_sink_pkg.sv
// Shared constants for the double-buffered display sink: ctrl bits and status layout.
package display_buffer_sink_pkg;

  localparam int unsigned CTRL_W     = 8;
  localparam int unsigned CTRL_CMD_W = 2;
  localparam int unsigned CTRL_WR    = 0;
  localparam int unsigned CTRL_SWAP  = 1;

  localparam int unsigned STATUS_W       = 8;
  localparam int unsigned STAT_FRONT     = 0;
  localparam int unsigned STAT_SWAP_PEND = 1;
  localparam int unsigned STAT_WR_PEND   = 2;

  // Pack the status byte seen by the PIO input port.
  function automatic logic [STATUS_W-1:0] make_status(input logic wr_pending,
                                                      input logic swap_pending,
                                                      input logic front_bank);
    logic [STATUS_W-1:0] s;
    s                 = '0;
    s[STAT_WR_PEND]   = wr_pending;
    s[STAT_SWAP_PEND] = swap_pending;
    s[STAT_FRONT]     = front_bank;
    return s;
  endfunction

endpackage

// File: rtl/display_buffer_ram.sv
// Simple dual-port RAM, one write port and a registered read port (block-RAM friendly).
module display_buffer_ram #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; output register clears on reset and holds between reads.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/display_buffer_sink.sv
// Double-buffered frame store fed by PIO toggle commands and read by the tile scanner.
module display_buffer_sink
  import display_buffer_sink_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] buf_addr,
  input  logic [DATA_W-1:0] buf_data,
  input  logic [7:0]        buf_ctrl,
  input  logic              frame_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [7:0]        status,
  output logic              swap_done
);

  localparam int unsigned RAM_AW = ADDR_W + 1;

  logic [CTRL_CMD_W-1:0] ctrl_q;
  logic                  front_bank;
  logic                  swap_pending;
  logic                  wr_pending;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_W-1:0]     wr_data_q;

  logic                  wr_cmd;
  logic                  swap_cmd;
  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_waddr;
  logic [RAM_AW-1:0]     ram_raddr;
  logic                  unused_ctrl_bits;

  // A command is any edge on a ctrl bit relative to last cycle's value.
  assign wr_cmd   = buf_ctrl[CTRL_WR] ^ ctrl_q[CTRL_WR];
  assign swap_cmd = buf_ctrl[CTRL_SWAP] ^ ctrl_q[CTRL_SWAP];
  assign unused_ctrl_bits = ^buf_ctrl[7:CTRL_CMD_W];

  // Control path: ctrl history, write commit flag, swap arbitration, read qualifier.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= buf_ctrl[CTRL_CMD_W-1:0];
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      wr_pending   <= 1'b0;
      swap_done    <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      ctrl_q     <= buf_ctrl[CTRL_CMD_W-1:0];
      wr_pending <= wr_cmd;
      rd_valid   <= rd_en;
      swap_done  <= 1'b0;
      // A toggle arriving while a swap is already pending folds into that swap.
      if (frame_start && swap_pending) begin
        front_bank   <= ~front_bank;
        swap_pending <= 1'b0;
        swap_done    <= 1'b1;
      end else if (swap_cmd) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Capture the write payload on the command cycle for commit next cycle.
  always_ff @(posedge clk) begin
    if (wr_cmd) begin
      wr_addr_q <= buf_addr;
      wr_data_q <= buf_data;
    end
  end

  // Writes go to the back bank, reads to the front bank, so the ports never collide.
  assign ram_we    = wr_pending & ~reset;
  assign ram_waddr = {~front_bank, wr_addr_q};
  assign ram_raddr = {front_bank, rd_addr};

  display_buffer_ram #(
    .AW (RAM_AW),
    .DW (DATA_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (wr_data_q),
    .re    (rd_en),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  assign status = make_status(wr_pending, swap_pending, front_bank);

endmodule
